// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit scheduler: FSM state codes and
// default 8N1 timing at 50 MHz / 9600 baud.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int BIT_CYCLES_DEF = 5208;
  localparam int FRAME_BITS_DEF = 10;
  localparam int DATA_W         = 8;

endpackage

// File: rtl/uart_rr_picker.sv
// Rotating-priority encoder: returns the first valid requester found when
// searching upward (with wrap) from rr_ptr.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  int idx;

  // Scan from the farthest candidate back to rr_ptr so the closest one wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        winner    = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART transmitter between NUM_REQ
// byte producers; frame and inter-frame gap are timed locally.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  BIT_CYCLES = BIT_CYCLES_DEF,
  parameter int  FRAME_BITS = FRAME_BITS_DEF,
  parameter int  GAP_CYCLES = 16,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  localparam int FRAME_LEN = FRAME_BITS * BIT_CYCLES;
  localparam int CNT_MAX   = (FRAME_LEN > GAP_CYCLES) ? FRAME_LEN : GAP_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [1:0]       FRAME_EXIT = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   grant_reg;
  logic [DATA_W-1:0] tx_data_reg;
  logic [ID_W-1:0]   winner;
  logic              any_valid;
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign data_arr[gi]  = req_data[DATA_W*gi +: DATA_W];
      assign req_ready[gi] = (state_reg == ST_START) && (grant_reg == ID_W'(gi));
    end
  endgenerate

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      rr_ptr_reg  <= '0;
      grant_reg   <= '0;
      tx_data_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arb_en && any_valid) begin
            tx_data_reg <= data_arr[winner];
            grant_reg   <= winner;
            // Rotate past the granted index, not past the old pointer.
            rr_ptr_reg  <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            state_reg   <= ST_START;
          end
        end
        ST_START: begin
          cnt_reg   <= '0;
          state_reg <= ST_BUSY;
        end
        ST_BUSY: begin
          if (cnt_reg == FRAME_LAST) begin
            cnt_reg   <= '0;
            state_reg <= FRAME_EXIT;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state, never of the inputs.
  assign tx_start = (state_reg == ST_START);
  assign busy     = (state_reg != ST_IDLE);
  assign tx_data  = tx_data_reg;
  assign grant_id = grant_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler (BIT_CYCLES=8, FRAME_BITS=10):
// main instance with GAP_CYCLES=2, second instance with GAP_CYCLES=0.
module tb_uart_tx_scheduler;

  localparam int NR = 4;

  typedef struct {
    int gid;
    int data;
    int exp_cyc;  // absolute cycle of tx_start, -1 = unchecked
    int exp_gap;  // cycles since previous tx_start, 0 = unchecked
  } exp_t;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        arb_en = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  sticky = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic [1:0]  grant_id;

  logic        rst1 = 1'b1;
  logic        arb_en1 = 1'b1;
  logic [3:0]  req_valid1 = '0;
  logic [31:0] req_data1 = '0;
  logic [3:0]  req_ready1;
  logic        tx_start1;
  logic [7:0]  tx_data1;
  logic        busy1;
  logic [1:0]  grant_id1;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_start = 0;
  int   exp_starts = 0;
  int   last_start = 0;
  bit   done1 = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  uart_tx_scheduler #(
    .NUM_REQ(4), .BIT_CYCLES(8), .FRAME_BITS(10), .GAP_CYCLES(2)
  ) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .arb_en(arb_en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .grant_id(grant_id)
  );

  uart_tx_scheduler #(
    .NUM_REQ(4), .BIT_CYCLES(8), .FRAME_BITS(10), .GAP_CYCLES(0)
  ) dut_nogap (
    .sys_clk(clk), .sys_rst(rst1), .arb_en(arb_en1),
    .req_valid(req_valid1), .req_data(req_data1), .req_ready(req_ready1),
    .tx_start(tx_start1), .tx_data(tx_data1), .busy(busy1), .grant_id(grant_id1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic post(input int lane, input logic [7:0] d, input bit stick);
    req_data[lane*8 +: 8] = d;
    sticky[lane]          = stick;
    req_valid[lane]       = 1'b1;
  endtask

  task automatic expect_grant(input int gid, input int d, input int ec, input int eg);
    exp_q.push_back('{gid, d, ec, eg});
    exp_starts++;
  endtask

  task automatic wait_start();
    int b = 0;
    while (n_start < exp_starts && b < 1000) begin
      @(negedge clk);
      b++;
    end
    chk("wait_start", n_start, exp_starts);
  endtask

  task automatic wait_all();
    int b = 0;
    while ((n_start < exp_starts || busy) && b < 1000) begin
      @(negedge clk);
      b++;
    end
    chk("wait_starts", n_start, exp_starts);
    chk("wait_idle", int'(busy), 0);
  endtask

  // Requesters drop valid once their byte has been accepted.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++)
      if (req_ready[i] && !sticky[i]) req_valid[i] = 1'b0;
  end

  // Monitor: every tx_start is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!sys_rst) begin
      if (tx_start) begin
        n_start++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_tx_start: got grant %0d data %0d, required no start (cycle %0d)",
                   grant_id, tx_data, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("grant_id", int'(grant_id), mon_e.gid);
          chk("tx_data", int'(tx_data), mon_e.data);
          chk("req_ready", int'(req_ready), 1 << mon_e.gid);
          if (mon_e.exp_cyc >= 0) chk("start_cycle", cyc, mon_e.exp_cyc);
          if (mon_e.exp_gap > 0) chk("start_spacing", cyc - last_start, mon_e.exp_gap);
        end
        last_start = cyc;
      end else if (req_ready != 4'b0000) begin
        chk("ready_without_start", int'(req_ready), 0);
      end
    end
  end

  initial begin
    int len;
    int b;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    sys_rst = 1'b0;
    arb_en  = 1'b1;
    @(negedge clk);

    // All four continuously valid: 0,1,2,3,0 spaced 84 cycles.
    post(0, 8'h10, 1'b1); post(1, 8'h11, 1'b1); post(2, 8'h12, 1'b1); post(3, 8'h13, 1'b1);
    expect_grant(0, 8'h10, cyc + 1, 0);
    expect_grant(1, 8'h11, -1, 84);
    expect_grant(2, 8'h12, -1, 84);
    expect_grant(3, 8'h13, -1, 84);
    expect_grant(0, 8'h10, -1, 84);
    wait_start();
    sticky    = '0;
    req_valid = '0;
    wait_all();

    // Single request on lane 2; pointer now at 1.
    @(negedge clk);
    post(2, 8'hA5, 1'b0);
    expect_grant(2, 8'hA5, cyc + 1, 0);
    @(negedge clk);
    len = 0;
    while (busy && len < 200) begin
      len++;
      @(negedge clk);
    end
    chk("busy_len", len, 83);
    wait_all();

    // Rotation: grant 3, then 0 and 2 together -> 0 then 2.
    post(3, 8'h3C, 1'b0);
    expect_grant(3, 8'h3C, cyc + 1, 0);
    wait_all();
    post(0, 8'hC0, 1'b0); post(2, 8'hC2, 1'b0);
    expect_grant(0, 8'hC0, cyc + 1, 0);
    expect_grant(2, 8'hC2, -1, 84);
    wait_all();

    // arb_en dropped mid-frame: frame completes, no new grant until re-enabled.
    post(3, 8'h77, 1'b0);
    expect_grant(3, 8'h77, cyc + 1, 0);
    wait_start();
    repeat (10) @(negedge clk);
    arb_en = 1'b0;
    post(0, 8'h01, 1'b0);
    b = 0;
    while (busy && b < 200) begin
      @(negedge clk);
      b++;
    end
    repeat (30) @(negedge clk);
    chk("held_no_start", n_start, exp_starts);
    chk("held_busy", int'(busy), 0);
    arb_en = 1'b1;
    expect_grant(0, 8'h01, cyc + 1, 0);
    wait_all();

    // Async reset mid-frame, then pointer restarts at 0: lane 1 before lane 3.
    post(1, 8'h5A, 1'b0);
    expect_grant(1, 8'h5A, cyc + 1, 0);
    wait_start();
    repeat (20) @(negedge clk);
    sys_rst = 1'b1;
    #1;
    chk("midrst_tx_start", int'(tx_start), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_tx_data", int'(tx_data), 0);
    chk("midrst_req_ready", int'(req_ready), 0);
    chk("midrst_grant_id", int'(grant_id), 0);
    post(3, 8'hE3, 1'b0); post(1, 8'hE1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    expect_grant(1, 8'hE1, cyc + 1, 0);
    expect_grant(3, 8'hE3, -1, 84);
    wait_all();

    b = 0;
    while (!done1 && b < 2000) begin
      @(negedge clk);
      b++;
    end
    chk("nogap_done", int'(done1), 1);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // GAP_CYCLES=0 instance: back-to-back frames, one idle cycle between them.
  initial begin
    int t[3] = '{0, 0, 0};
    int g[3] = '{-1, -1, -1};
    int d[3] = '{-1, -1, -1};
    int idle_cnt[3] = '{0, 0, 0};
    int k = 0;
    int b = 0;
    req_valid1 = 4'b0011;
    req_data1  = 32'h0000_4140;
    repeat (3) @(negedge clk);
    rst1 = 1'b0;
    while (k < 3 && b < 1000) begin
      @(negedge clk);
      b++;
      if (tx_start1) begin
        t[k] = cyc;
        g[k] = int'(grant_id1);
        d[k] = int'(tx_data1);
        k++;
      end else if (!busy1 && k > 0) begin
        idle_cnt[k]++;
      end
    end
    chk("nogap_starts", k, 3);
    chk("nogap_gid0", g[0], 0);
    chk("nogap_gid1", g[1], 1);
    chk("nogap_gid2", g[2], 0);
    chk("nogap_data0", d[0], 8'h40);
    chk("nogap_data1", d[1], 8'h41);
    chk("nogap_spacing1", t[1] - t[0], 82);
    chk("nogap_spacing2", t[2] - t[1], 82);
    chk("nogap_idle1", idle_cnt[1], 1);
    chk("nogap_idle2", idle_cnt[2], 1);
    req_valid1 = '0;
    done1 = 1'b1;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one 8N1 UART transmitter between NUM_REQ requesters using round-robin arbitration. It captures one byte from the granted requester and issues a single-cycle start pulse with held data to the transmitter. It then times the frame and an inter-frame gap locally, because the transmitter exposes no busy/done signal. It sits between the byte-producing clients and the UART TX datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BIT_CYCLES, 5208, sys_clk cycles per UART bit (50 MHz / 9600 baud)
FRAME_BITS, 10, bits per frame (start + 8 data + stop)
GAP_CYCLES, 16, idle cycles enforced after each frame before the next grant (0 allowed)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  asynchronous, active-high reset
arb_en  in  1  1 = new grants allowed; 0 = finish current frame, then hold IDLE
req_valid  in  NUM_REQ  per-requester byte pending; held with data until req_ready
req_data  in  8*NUM_REQ  requester i byte at [8*i+7:8*i]
req_ready  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted
tx_start  out  1  one-cycle start pulse to transmitter
tx_data  out  8  byte to transmit; stable from tx_start until the next grant
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(NUM_REQ)  index of last granted requester; valid while busy

Behaviour:
- Reset (async, any state): state=IDLE, req_ready=0, tx_start=0, tx_data=8'h00, busy=0, grant_id=0, rr_ptr=0, counters=0.
- All outputs registered; no combinational path from inputs to outputs.
- States: IDLE, START, BUSY, GAP.
- IDLE: if arb_en=1 and |req_valid, select winner = first i with req_valid[i]=1 searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. On that edge: tx_data<=req_data[winner], grant_id<=winner, rr_ptr<=(winner+1) mod NUM_REQ, state->START.
- START (exactly 1 cycle): tx_start=1, req_ready[grant_id]=1, busy=1; req_valid not sampled. Next state BUSY, frame counter=0.
- BUSY: frame counter increments each cycle; at FRAME_BITS*BIT_CYCLES-1 -> GAP (or IDLE if GAP_CYCLES=0), counter cleared. Default frame length 52080 cycles; counter width $clog2(FRAME_BITS*BIT_CYCLES).
- GAP: counter increments; at GAP_CYCLES-1 -> IDLE.
- Latency: req_valid high in IDLE at edge t -> tx_start/req_ready high in cycle t+1. Minimum spacing between consecutive tx_start pulses = 1+FRAME_BITS*BIT_CYCLES+GAP_CYCLES+1 cycles.
- Requester contract: hold req_valid and req_data stable until req_ready; may change them in the cycle after req_ready. A requester deasserting valid before grant is legal and is simply not selected.
- arb_en: sampled only in IDLE; deassertion during START/BUSY/GAP does not abort the frame.
- Fairness: with all requesters continuously valid, grants go 0,1,2,3,0,... Rotation is based on the granted index, not on the pointer.
- Simultaneous valid on several requesters: only the round-robin winner receives req_ready; others stay pending with no loss.
- tx_data and grant_id are not cleared on return to IDLE.
- Reset mid-frame: immediate return to reset values. The in-flight byte is dropped; the requester saw no req_ready only if reset hit before START.

Decomposition:
- Shared package uart_pkg: state encoding localparams (IDLE/START/BUSY/GAP), default BIT_CYCLES=5208, FRAME_BITS=10, 8N1 data width constant.
- One sub-module: uart_rr_picker, a combinational rotating-priority encoder (req_valid, rr_ptr -> winner, any_valid). The FSM, counters and registers stay in uart_tx_scheduler.

Test Plan:
Sim parameters BIT_CYCLES=8, FRAME_BITS=10, GAP_CYCLES=2, NUM_REQ=4.
- Single request: req_valid=4'b0100, data2=8'hA5 at edge t -> tx_start and req_ready=4'b0100 in cycle t+1, tx_data=8'hA5, grant_id=2, busy high for 83 cycles, then IDLE.
- All four valid continuously (data 8'h10..8'h13) -> grant order 0,1,2,3,0; tx_start pulses exactly 84 cycles apart; tx_data 10,11,12,13,10.
- rr_ptr rotation: grant 3, then requesters 0 and 2 both valid -> requester 0 granted next, then 2.
- arb_en dropped mid-BUSY with req_valid=4'b0001 pending -> frame completes, no further tx_start until arb_en=1, then grant in next cycle.
- Async sys_rst pulse mid-BUSY -> outputs immediately tx_start=0, busy=0, tx_data=8'h00, req_ready=0; after release a pending request is granted to the lowest valid index.
- GAP_CYCLES=0 build: back-to-back requests -> tx_start spacing = 82 cycles; no GAP state entered.
